bip_control_unit: RTL and testbench
===================================

# bip_control_unit

Instruction sequencer for the BIP processor. Owns the program counter, drives the address of the synchronous program memory, and decodes each fetched 16-bit instruction into one cycle of datapath control strobes (accumulator, ALU, data RAM). Also counts elapsed clock cycles until `HLT` for reporting to the host. Sits between the program memory and the accumulator/ALU/data-RAM datapath.

## Interface
- `PC_BITS`, 11: program counter / program memory address width
- `INST_BITS`, 16: instruction width
- `OPCODE_BITS`, 5: opcode field width, `i_instruction[15:11]`
- `OPERAND_BITS`, 11: operand field width, `i_instruction[10:0]`
- `COUNT_BITS`, 32: cycle counter width

- `clk` input 1: single clock; all state updates on rising edge
- `rst` input 1: reset, synchronous and active-low
- `o_pc` output PC_BITS: program memory address
- `i_instruction` input INST_BITS: program memory data, valid one cycle after `o_pc` is presented
- `o_operand` output OPERAND_BITS: operand field to sign-extender / data RAM address
- `o_sel_a` output 2: accumulator source; 0 = data RAM, 1 = immediate, 2 = ALU result
- `o_sel_b` output 1: ALU operand B; 0 = data RAM, 1 = immediate
- `o_op` output 1: ALU operation; 0 = add, 1 = subtract
- `o_wr_acc` output 1: accumulator write enable
- `o_rd_ram` output 1: data RAM read enable
- `o_wr_ram` output 1: data RAM write enable
- `o_halt` output 1: processor halted
- `o_clk_count` output COUNT_BITS: cycles elapsed since reset

## Operation
- FSM states: FETCH, EXEC, HALT. Reset state FETCH.
- FETCH: `o_pc` = PC; all strobes 0. Next state EXEC.
- EXEC: `i_instruction` valid; decode opcode, drive strobes for exactly this cycle.
  - opcode `HLT` (00000): next state HALT; PC unchanged.
  - any other opcode: PC <= PC + 1 (modulo 2^PC_BITS, so all-ones wraps to 0); next state FETCH.
- Decode in EXEC (unlisted outputs 0):
  - `STO` 00001: `o_wr_ram`=1
  - `LD` 00010: `o_rd_ram`=1, `o_sel_a`=0, `o_wr_acc`=1
  - `LDI` 00011: `o_sel_a`=1, `o_wr_acc`=1
  - `ADD` 00100: `o_rd_ram`=1, `o_sel_b`=0, `o_op`=0, `o_sel_a`=2, `o_wr_acc`=1
  - `ADDI` 00101: `o_sel_b`=1, `o_op`=0, `o_sel_a`=2, `o_wr_acc`=1
  - `SUB` 00110: `o_rd_ram`=1, `o_sel_b`=0, `o_op`=1, `o_sel_a`=2, `o_wr_acc`=1
  - `SUBI` 00111: `o_sel_b`=1, `o_op`=1, `o_sel_a`=2, `o_wr_acc`=1
  - opcodes 01000–11111: NOP; all strobes 0, PC advances.
- `o_operand` = `i_instruction[10:0]` in EXEC, 0 otherwise.
- HALT: terminal; all strobes 0; PC and `o_clk_count` frozen; `o_halt`=1. Exit only by reset.
- Cycle counter: +1 on every clock edge where state is not HALT and `rst`=1; saturates at all-ones.

## Timing
- Reset (`rst`=0 sampled at edge): next cycle state FETCH, PC=0, `o_pc`=0, `o_clk_count`=0, `o_halt`=0, all strobes/selects/`o_op`/`o_operand`=0. Reset in any state, including mid-EXEC, overrides all other updates.
- Strobes and selects are combinational from state + `i_instruction`; no strobe asserted in FETCH or HALT.
- Throughput: 2 cycles per instruction. Instruction at address k executes in cycles 2k+1 (FETCH) and 2k+2 (EXEC) after reset release, absent wrap.
- `HLT` at address k: `o_halt` rises the cycle after its EXEC; `o_clk_count` final value = 2(k+1); `o_pc` stays k.
- `o_pc` changes only on the edge leaving EXEC.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random `i_instruction` -> `o_pc`=0, `o_clk_count`=0, `o_halt`=0, all strobes 0; first FETCH presents `o_pc`=0.
- Program `LDI 5; ADDI 3; STO 2; HLT` via 1-cycle-latency memory model -> EXEC cycles show (`o_sel_a`=1,`o_wr_acc`=1,`o_operand`=5), (`o_sel_b`=1,`o_op`=0,`o_sel_a`=2,`o_wr_acc`=1,`o_operand`=3), (`o_wr_ram`=1,`o_operand`=2); then `o_halt`=1, `o_pc`=3, `o_clk_count`=8 and frozen for 20 further cycles.
- `LD 7; SUB 4; SUBI 1; HLT` -> strobe sets per decode list, each exactly one cycle, none in FETCH.
- Opcode 11111 followed by `HLT` -> no strobes, PC advances to 1, halt with `o_clk_count`=4.
- `PC_BITS`=3, memory filled with NOPs -> `o_pc` sequence 0..7 then 0; no halt.
- Deassert-then-assert reset during EXEC of `ADD` and while in HALT -> strobes drop next cycle, PC=0, counter 0, `o_halt`=0, program re-executes from address 0.

Source files
------------

// File: rtl/bip_control_unit_if.sv
// Program-memory and datapath-control bus of the BIP control unit.
// The master side is the sequencer; the slave side is memory plus datapath.
interface bip_control_unit_if #(
  parameter int PC_BITS      = 11,
  parameter int INST_BITS    = 16,
  parameter int OPERAND_BITS = 11,
  parameter int COUNT_BITS   = 32
);
  logic [PC_BITS-1:0]      o_pc;
  logic [INST_BITS-1:0]    i_instruction;
  logic [OPERAND_BITS-1:0] o_operand;
  logic [1:0]              o_sel_a;
  logic                    o_sel_b;
  logic                    o_op;
  logic                    o_wr_acc;
  logic                    o_rd_ram;
  logic                    o_wr_ram;
  logic                    o_halt;
  logic [COUNT_BITS-1:0]   o_clk_count;

  modport master (
    output o_pc, o_operand, o_sel_a, o_sel_b, o_op,
    output o_wr_acc, o_rd_ram, o_wr_ram, o_halt, o_clk_count,
    input  i_instruction
  );

  modport slave (
    input  o_pc, o_operand, o_sel_a, o_sel_b, o_op,
    input  o_wr_acc, o_rd_ram, o_wr_ram, o_halt, o_clk_count,
    output i_instruction
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: two-cycle FETCH/EXEC loop, one-cycle decode strobes,
// terminal HALT and a saturating cycle counter for the host.
module bip_control_unit #(
  parameter int PC_BITS      = 11,
  parameter int INST_BITS    = 16,
  parameter int OPCODE_BITS  = 5,
  parameter int OPERAND_BITS = 11,
  parameter int COUNT_BITS   = 32
) (
  input  logic               clk,
  input  logic               rst,
  bip_control_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);

  localparam logic [COUNT_BITS-1:0] COUNT_MAX = {COUNT_BITS{1'b1}};

  state_t                  state_r;
  logic [PC_BITS-1:0]      pc_r;
  logic [COUNT_BITS-1:0]   count_r;
  logic                    halt_r;

  logic [OPCODE_BITS-1:0]  opcode_s;
  logic [OPERAND_BITS-1:0] operand_s;
  logic [1:0]              sel_a_s;
  logic                    sel_b_s;
  logic                    op_s;
  logic                    wr_acc_s;
  logic                    rd_ram_s;
  logic                    wr_ram_s;

  assign opcode_s = bus.i_instruction[INST_BITS-1 -: OPCODE_BITS];

  // Sequencer state, program counter, halt flag and cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= FETCH;
      pc_r    <= {PC_BITS{1'b0}};
      count_r <= {COUNT_BITS{1'b0}};
      halt_r  <= 1'b0;
    end else begin
      // Counter stops once halted so the host reads the program's run time.
      if ((state_r != HALT) && (count_r != COUNT_MAX)) begin
        count_r <= count_r + COUNT_BITS'(1);
      end
      case (state_r)
        FETCH: state_r <= EXEC;
        EXEC: begin
          if (opcode_s == OP_HLT) begin
            state_r <= HALT;
            halt_r  <= 1'b1;
          end else begin
            pc_r    <= pc_r + PC_BITS'(1);
            state_r <= FETCH;
          end
        end
        HALT:    state_r <= HALT;
        default: state_r <= FETCH;
      endcase
    end
  end

  // Single-cycle decode of the fetched instruction; quiet outside EXEC.
  always_comb begin
    sel_a_s   = 2'd0;
    sel_b_s   = 1'b0;
    op_s      = 1'b0;
    wr_acc_s  = 1'b0;
    rd_ram_s  = 1'b0;
    wr_ram_s  = 1'b0;
    operand_s = {OPERAND_BITS{1'b0}};
    if (state_r == EXEC) begin
      operand_s = bus.i_instruction[OPERAND_BITS-1:0];
      case (opcode_s)
        OP_STO: wr_ram_s = 1'b1;
        OP_LD: begin
          rd_ram_s = 1'b1;
          wr_acc_s = 1'b1;
        end
        OP_LDI: begin
          sel_a_s  = 2'd1;
          wr_acc_s = 1'b1;
        end
        OP_ADD: begin
          rd_ram_s = 1'b1;
          sel_a_s  = 2'd2;
          wr_acc_s = 1'b1;
        end
        OP_ADDI: begin
          sel_b_s  = 1'b1;
          sel_a_s  = 2'd2;
          wr_acc_s = 1'b1;
        end
        OP_SUB: begin
          rd_ram_s = 1'b1;
          op_s     = 1'b1;
          sel_a_s  = 2'd2;
          wr_acc_s = 1'b1;
        end
        OP_SUBI: begin
          sel_b_s  = 1'b1;
          op_s     = 1'b1;
          sel_a_s  = 2'd2;
          wr_acc_s = 1'b1;
        end
        default: wr_ram_s = 1'b0;
      endcase
    end else begin
      operand_s = {OPERAND_BITS{1'b0}};
    end
  end

  assign bus.o_pc        = pc_r;
  assign bus.o_halt      = halt_r;
  assign bus.o_clk_count = count_r;
  assign bus.o_operand   = operand_s;
  assign bus.o_sel_a     = sel_a_s;
  assign bus.o_sel_b     = sel_b_s;
  assign bus.o_op        = op_s;
  assign bus.o_wr_acc    = wr_acc_s;
  assign bus.o_rd_ram    = rd_ram_s;
  assign bus.o_wr_ram    = wr_ram_s;

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed + random programs for bip_control_unit, checked cycle by cycle against
// a model that derives each cycle's outputs from the program and the 2-cycle schedule.
module tb_bip_control_unit;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic rand_mode = 1'b1;

  always #5 clk = ~clk;

  bip_control_unit_if #(.PC_BITS(11), .INST_BITS(16), .OPERAND_BITS(11), .COUNT_BITS(32)) bus ();
  bip_control_unit_if #(.PC_BITS(3),  .INST_BITS(16), .OPERAND_BITS(11), .COUNT_BITS(32)) bus3 ();

  bip_control_unit #(.PC_BITS(11), .INST_BITS(16), .OPCODE_BITS(5), .OPERAND_BITS(11), .COUNT_BITS(32))
    dut (.clk(clk), .rst(rst), .bus(bus));
  bip_control_unit #(.PC_BITS(3), .INST_BITS(16), .OPCODE_BITS(5), .OPERAND_BITS(11), .COUNT_BITS(32))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [15:0] mem [0:2047];
  int n_cmp = 0;
  int n_bad = 0;

  wire [6:0] ctrl  = {bus.o_sel_a, bus.o_sel_b, bus.o_op, bus.o_wr_acc, bus.o_rd_ram, bus.o_wr_ram};
  wire [6:0] ctrl3 = {bus3.o_sel_a, bus3.o_sel_b, bus3.o_op, bus3.o_wr_acc, bus3.o_rd_ram, bus3.o_wr_ram};

  // Synchronous program memory (1-cycle latency); the small core only ever sees NOPs.
  always @(posedge clk) begin
    if (rand_mode) bus.i_instruction <= 16'($urandom);
    else           bus.i_instruction <= mem[bus.o_pc];
    bus3.i_instruction <= {5'(8 + $urandom_range(23, 0)), 11'($urandom)};
  end

  function automatic logic [15:0] ins(input int opc, input int operand);
    return {5'(opc), 11'(operand)};
  endfunction

  // Expected {sel_a, sel_b, op, wr_acc, rd_ram, wr_ram} straight from the decode list.
  function automatic logic [6:0] exp_ctrl(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_0_1;
      5'd2:    return 7'b00_0_0_1_1_0;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_1_0;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_1_0;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b00_0_0_0_0_0;
    endcase
  endfunction

  function automatic int first_hlt();
    for (int i = 0; i < 2048; i++) begin
      if (mem[i][15:11] == 5'd0) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  // Cycle c counts from 1 = first FETCH after reset release.
  task automatic check_cycle(input int c, input int h);
    int k;
    logic [15:0] w;
    if ((h >= 0) && (c > 2 * h + 2)) begin
      chk("halt_pc",    32'(bus.o_pc),        32'(h));
      chk("halt_ctrl",  32'(ctrl),            32'd0);
      chk("halt_oper",  32'(bus.o_operand),   32'd0);
      chk("halt_flag",  32'(bus.o_halt),      32'd1);
      chk("halt_count", bus.o_clk_count,      32'(2 * h + 2));
    end else begin
      k = ((c - 1) / 2) % 2048;
      w = mem[k];
      chk("pc",    32'(bus.o_pc),   32'(k));
      chk("halt",  32'(bus.o_halt), 32'd0);
      chk("count", bus.o_clk_count, 32'(c - 1));
      if (((c - 1) % 2) == 1) begin
        chk("exec_ctrl", 32'(ctrl),          32'(exp_ctrl(w[15:11])));
        chk("exec_oper", 32'(bus.o_operand), 32'(w[10:0]));
      end else begin
        chk("fetch_ctrl", 32'(ctrl),          32'd0);
        chk("fetch_oper", 32'(bus.o_operand), 32'd0);
      end
    end
  endtask

  // Called at a negedge; holds reset for n edges, checks, releases at a negedge (= cycle 1).
  task automatic do_reset(input int n);
    rand_mode = 1'b1;
    rst = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_pc",    32'(bus.o_pc),      32'd0);
      chk("rst_count", bus.o_clk_count,    32'd0);
      chk("rst_halt",  32'(bus.o_halt),    32'd0);
      chk("rst_ctrl",  32'(ctrl),          32'd0);
      chk("rst_oper",  32'(bus.o_operand), 32'd0);
      chk("rst3_pc",   32'(bus3.o_pc),     32'd0);
      chk("rst3_cnt",  bus3.o_clk_count,   32'd0);
    end
    rand_mode = 1'b0;
    rst = 1'b1;
  endtask

  task automatic run(input int from, input int upto);
    int h;
    h = first_hlt();
    for (int c = from; c <= upto; c++) begin
      check_cycle(c, h);
      @(negedge clk);
    end
  endtask

  initial begin
    int len;
    @(negedge clk);

    // LDI 5; ADDI 3; STO 2; HLT then 20+ frozen cycles
    clear_mem();
    mem[0] = ins(3, 5); mem[1] = ins(5, 3); mem[2] = ins(1, 2); mem[3] = ins(0, 0);
    do_reset(3);
    run(1, 8 + 21);

    // LD 7; SUB 4; SUBI 1; HLT
    clear_mem();
    mem[0] = ins(2, 7); mem[1] = ins(6, 4); mem[2] = ins(7, 1); mem[3] = ins(0, 0);
    do_reset(1);
    run(1, 8 + 4);

    // Opcode 11111 then HLT
    clear_mem();
    mem[0] = ins(31, $urandom_range(2047, 0)); mem[1] = ins(0, 0);
    do_reset(2);
    run(1, 4 + 5);

    // 3-bit PC over a NOP-only memory: 0..7 then wrap, never halts
    do_reset(2);
    for (int c = 1; c <= 40; c++) begin
      chk("pc3",    32'(bus3.o_pc),     32'(((c - 1) / 2) % 8));
      chk("halt3",  32'(bus3.o_halt),   32'd0);
      chk("count3", bus3.o_clk_count,   32'(c - 1));
      chk("ctrl3",  32'(ctrl3),         32'd0);
      @(negedge clk);
    end

    // Reset in the middle of ADD's EXEC, re-run, then reset while halted and re-run
    clear_mem();
    mem[0] = ins(4, 9); mem[1] = ins(3, 1); mem[2] = ins(0, 0);
    do_reset(1);
    run(1, 1);
    check_cycle(2, first_hlt());
    do_reset(1);
    run(1, 6 + 5);
    do_reset(2);
    run(1, 6 + 3);

    // Random programs: non-HLT opcodes with random operands, terminated by HLT
    for (int p = 0; p < 4; p++) begin
      clear_mem();
      len = $urandom_range(12, 3);
      for (int i = 0; i < len; i++) mem[i] = ins($urandom_range(31, 1), $urandom_range(2047, 0));
      mem[len] = ins(0, $urandom_range(2047, 0));
      do_reset($urandom_range(3, 1));
      run(1, 2 * len + 2 + 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
